// File: rtl/adc_edge_trigger.sv
// Edge trigger on 8-lane signed ADC beats: 2-cycle fixed pass-through, flags the first qualified crossing.
// No backpressure: bubbles flow through untouched. TRIG_TIMESTAMP_EN adds out_trig_ts.
module adc_edge_trigger #(
    parameter  int LANES     = 8,
    parameter  int SAMPLE_W  = 8,
    parameter  int HOLDOFF_W = 16,
    localparam int DATA_W    = LANES * SAMPLE_W,
    localparam int IDX_W     = $clog2(LANES)
) (
    input  logic                 divclk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 cfg_arm,
    input  logic                 cfg_rising,
    input  logic [SAMPLE_W-1:0]  cfg_threshold,
    input  logic [SAMPLE_W-1:0]  cfg_hyst,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    output logic                 out_trig,
    output logic [IDX_W-1:0]     out_trig_idx,
`ifdef TRIG_TIMESTAMP_EN
    output logic [31:0]          out_trig_ts,
`endif
    output logic                 armed
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_PRIMED  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam logic signed [SAMPLE_W+1:0] S_MAX = (SAMPLE_W+2)'((1 << (SAMPLE_W-1)) - 1);
    localparam logic signed [SAMPLE_W+1:0] S_MIN = ~S_MAX;

    // ---------------- stage 1: per-lane threshold flags ----------------
    logic signed [SAMPLE_W+1:0] thr_x;
    logic signed [SAMPLE_W+1:0] hyst_x;
    logic signed [SAMPLE_W+1:0] alt_x;
    logic signed [SAMPLE_W-1:0] alt_s;
    logic signed [SAMPLE_W-1:0] thr_s;
    logic [LANES-1:0]           hi_d;
    logic [LANES-1:0]           lo_d;

    assign thr_s  = cfg_threshold;
    assign thr_x  = {{2{cfg_threshold[SAMPLE_W-1]}}, cfg_threshold};
    assign hyst_x = {2'b00, cfg_hyst};
    assign alt_x  = cfg_rising ? (thr_x - hyst_x) : (thr_x + hyst_x);

    // The re-arm level lives on the far side of the threshold and saturates to the sample range.
    always_comb begin
        alt_s = alt_x[SAMPLE_W-1:0];
        if (alt_x > S_MAX) begin
            alt_s = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (alt_x < S_MIN) begin
            alt_s = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [SAMPLE_W-1:0] smp;
        assign smp      = in_data[gi*SAMPLE_W +: SAMPLE_W];
        assign hi_d[gi] = cfg_rising ? (smp >= thr_s) : (smp <= thr_s);
        assign lo_d[gi] = cfg_rising ? (smp <= alt_s) : (smp >= alt_s);
    end

    logic [DATA_W-1:0]    s1_data_q;
    logic                 s1_vld_q;
    logic [LANES-1:0]     s1_hi_q;
    logic [LANES-1:0]     s1_lo_q;
    logic [HOLDOFF_W-1:0] s1_holdoff_q;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]          ts_cnt_q;
    logic [31-IDX_W:0]    s1_ts_q;
`endif

    always_ff @(posedge divclk) begin
        if (rst) begin
            s1_data_q    <= '0;
            s1_vld_q     <= 1'b0;
            s1_hi_q      <= '0;
            s1_lo_q      <= '0;
            s1_holdoff_q <= '0;
`ifdef TRIG_TIMESTAMP_EN
            ts_cnt_q     <= '0;
            s1_ts_q      <= '0;
`endif
        end else begin
            s1_data_q    <= in_data;
            s1_vld_q     <= in_valid;
            s1_hi_q      <= hi_d;
            s1_lo_q      <= lo_d;
            s1_holdoff_q <= cfg_holdoff;
`ifdef TRIG_TIMESTAMP_EN
            if (in_valid) begin
                ts_cnt_q <= ts_cnt_q + 32'd1;
                s1_ts_q  <= ts_cnt_q[31-IDX_W:0];
            end
`endif
        end
    end

    // ---------------- stage 2: trigger FSM over lanes ----------------
    logic [1:0]           state_q, state_d;
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
    logic                 trig_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 primed;
    logic                 found;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        trig_d  = 1'b0;
        idx_d   = '0;
        primed  = (state_q == ST_PRIMED);
        found   = 1'b0;
        if (!cfg_arm) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_HOLDOFF: begin
                    if (s1_vld_q) begin
                        if (hcnt_q == HOLDOFF_W'(1)) begin
                            state_d = ST_WAIT;
                            hcnt_d  = '0;
                        end else begin
                            hcnt_d  = hcnt_q - HOLDOFF_W'(1);
                        end
                    end
                end
                default: begin
                    if (s1_vld_q) begin
                        // Trigger test precedes priming so a lane meeting both only primes.
                        for (int i = 0; i < LANES; i++) begin
                            if (!found) begin
                                if (primed && s1_hi_q[i]) begin
                                    found = 1'b1;
                                    idx_d = IDX_W'(i);
                                end else if (s1_lo_q[i]) begin
                                    primed = 1'b1;
                                end
                            end
                        end
                        trig_d = found;
                        if (found) begin
                            if (s1_holdoff_q == '0) begin
                                state_d = ST_WAIT;
                            end else begin
                                state_d = ST_HOLDOFF;
                                hcnt_d  = s1_holdoff_q;
                            end
                        end else begin
                            state_d = primed ? ST_PRIMED : ST_WAIT;
                        end
                    end
                end
            endcase
        end
    end

    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_trig_q;
    logic [IDX_W-1:0]  out_idx_q;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]       out_ts_q;
`endif

    always_ff @(posedge divclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_trig_q  <= 1'b0;
            out_idx_q   <= '0;
`ifdef TRIG_TIMESTAMP_EN
            out_ts_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            out_data_q  <= s1_data_q;
            out_valid_q <= s1_vld_q;
            out_trig_q  <= trig_d;
            out_idx_q   <= idx_d;
`ifdef TRIG_TIMESTAMP_EN
            if (trig_d) begin
                out_ts_q <= {s1_ts_q, idx_d};
            end
`endif
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_trig     = out_trig_q;
    assign out_trig_idx = out_idx_q;
    assign armed        = (state_q == ST_PRIMED);
`ifdef TRIG_TIMESTAMP_EN
    assign out_trig_ts  = out_ts_q;
`endif

endmodule

// File: tb/tb_adc_edge_trigger.sv
// Scoreboard bench for adc_edge_trigger: directed scenarios followed by randomized configs and beats.
module tb_adc_edge_trigger;

    logic        divclk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        cfg_arm;
    logic        cfg_rising;
    logic [7:0]  cfg_threshold;
    logic [7:0]  cfg_hyst;
    logic [15:0] cfg_holdoff;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_trig;
    logic [2:0]  out_trig_idx;
    logic        armed;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] out_trig_ts;
`endif

    always #5 divclk = ~divclk;

    adc_edge_trigger dut (
        .divclk        (divclk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .cfg_arm       (cfg_arm),
        .cfg_rising    (cfg_rising),
        .cfg_threshold (cfg_threshold),
        .cfg_hyst      (cfg_hyst),
        .cfg_holdoff   (cfg_holdoff),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_trig      (out_trig),
        .out_trig_idx  (out_trig_idx),
`ifdef TRIG_TIMESTAMP_EN
        .out_trig_ts   (out_trig_ts),
`endif
        .armed         (armed)
    );

    typedef int lanes_t [8];
    typedef struct {
        logic [63:0] d;
        bit          trig;
        logic [2:0]  idx;
        logic [31:0] ts;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;

    // Reference model: software view of the trigger rules.
    bit m_en, m_primed;
    int m_hold, m_bc;
    int c_rising, c_thr, c_hyst, c_hold;

    always @(posedge divclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input lanes_t l);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(l[i]);
        return r;
    endfunction

    function automatic logic [63:0] mk_all(input int v);
        lanes_t l;
        for (int i = 0; i < 8; i++) l[i] = v;
        return mk(l);
    endfunction

    task automatic model_beat(input logic [63:0] d, output bit trig, output logic [2:0] idx);
        int lvl;
        trig = 1'b0;
        idx  = 3'd0;
        if (!m_en) return;
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        if (c_rising != 0) lvl = (c_thr - c_hyst < -128) ? -128 : c_thr - c_hyst;
        else               lvl = (c_thr + c_hyst > 127)  ? 127  : c_thr + c_hyst;
        for (int i = 0; i < 8; i++) begin
            int s;
            bit crosses, rearms;
            s       = $signed(d[i*8 +: 8]);
            crosses = (c_rising != 0) ? (s >= c_thr) : (s <= c_thr);
            rearms  = (c_rising != 0) ? (s <= lvl)   : (s >= lvl);
            if (m_primed && crosses) begin
                trig     = 1'b1;
                idx      = 3'(i);
                m_primed = 1'b0;
                m_hold   = c_hold;
                return;
            end
            if (rearms) m_primed = 1'b1;
        end
    endtask

    task automatic send(input logic [63:0] d, input bit v);
        exp_t       e;
        bit         t;
        logic [2:0] ix;
        @(negedge divclk);
        in_data  = d;
        in_valid = v;
        if (v) begin
            model_beat(d, t, ix);
            e.d    = d;
            e.trig = t;
            e.idx  = ix;
            e.ts   = {m_bc[28:0], ix};
            e.cyc  = cyc;
            m_bc++;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge divclk);
            in_valid = 1'b0;
        end
    endtask

    task automatic check_armed(input string name);
        chk(name, armed, (m_en && m_hold == 0 && m_primed) ? 1 : 0);
    endtask

    task automatic configure(input int rising, input int thr, input int hyst, input int hold);
        idle(4);
        cfg_arm = 1'b0;
        m_en = 0; m_primed = 0; m_hold = 0;
        idle(4);
        cfg_rising    = (rising != 0);
        cfg_threshold = 8'(thr);
        cfg_hyst      = 8'(hyst);
        cfg_holdoff   = 16'(hold);
        c_rising = rising; c_thr = thr; c_hyst = hyst; c_hold = hold;
        idle(2);
        cfg_arm = 1'b1;
        m_en = 1;
        idle(4);
    endtask

    function automatic logic [63:0] rand_beat(input int thr, input int hyst);
        lanes_t l;
        int span, r, v;
        span = hyst + 24;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 2 * span);
            v = thr + r - span;
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
            l[i] = v;
        end
        return mk(l);
    endfunction

    // Monitor: pops one expectation per presented output beat.
    always @(negedge divclk) begin : mon
        exp_t e;
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: out_valid=1 with no pending beat, data=%0h", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_trig", out_trig, e.trig);
                    if (e.trig) chk("out_trig_idx", out_trig_idx, e.idx);
                    chk("latency", cyc - e.cyc, 2);
`ifdef TRIG_TIMESTAMP_EN
                    if (e.trig) chk("out_trig_ts", out_trig_ts, e.ts);
`endif
                end
            end else begin
                chk("trig_on_bubble", out_trig, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0;
        cfg_arm = 1'b0; cfg_rising = 1'b1; cfg_threshold = '0; cfg_hyst = '0; cfg_holdoff = '0;
        m_en = 0; m_primed = 0; m_hold = 0; m_bc = 0;
        c_rising = 1; c_thr = 0; c_hyst = 0; c_hold = 0;
        repeat (2) @(negedge divclk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_trig", out_trig, 0);
        chk("rst_out_trig_idx", out_trig_idx, 0);
        chk("rst_armed", armed, 0);
`ifdef TRIG_TIMESTAMP_EN
        chk("rst_out_trig_ts", out_trig_ts, 0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic rising crossing, then a beat that never re-arms, then one that does.
        configure(1, 0, 16, 0);
        send(mk('{-40, -20, -5, 5, 20, 40, 60, 80}), 1);
        send(mk('{-10, -5, 5, 10, 20, 30, 40, 50}), 1);
        send(mk('{-20, -5, 10, 20, 30, 40, 50, 60}), 1);
        idle(3);

        // Falling edge with holdoff 3.
        configure(0, 10, 5, 3);
        for (int k = 0; k < 10; k++) send(mk_all((k % 2 == 0) ? 20 : 0), 1);
        idle(3);

        // Re-arm level saturates at -128.
        configure(1, -120, 50, 0);
        send(mk('{-100, -110, -90, -128, -125, -120, -60, 0}), 1);
        send(mk_all(-128), 1);
        send(mk('{-125, -122, -120, 0, 0, 0, 0, 0}), 1);
        idle(3);

        // Zero hysteresis: a sample equal to threshold primes, the next one triggers.
        configure(1, 0, 0, 0);
        send(mk_all(0), 1);
        idle(3);

        // Holdoff 2 with bubbles interleaved.
        configure(1, 0, 16, 2);
        for (int k = 0; k < 6; k++) begin
            send(mk('{-40, 40, -40, 40, -40, 40, -40, 40}), 1);
            send(mk_all(0), 0);
            send(mk_all(0), 0);
        end
        idle(3);

        // Reset while primed.
        configure(1, 0, 16, 0);
        send(mk_all(-40), 1);
        idle(3);
        check_armed("armed_before_rst");
        rst = 1'b1;
        m_primed = 0; m_hold = 0; m_bc = 0;
        @(negedge divclk);
        check_armed("armed_after_rst");
        chk("valid_after_rst", out_valid, 0);
        rst = 1'b0;
        idle(3);
        send(mk_all(40), 1);
        send(mk('{-40, 40, 40, 40, 40, 40, 40, 40}), 1);
        idle(3);

        // Disarm while primed.
        send(mk_all(-40), 1);
        idle(3);
        check_armed("armed_before_disarm");
        cfg_arm = 1'b0;
        m_en = 0; m_primed = 0; m_hold = 0;
        @(negedge divclk);
        check_armed("armed_after_disarm");
        idle(2);
        cfg_arm = 1'b1;
        m_en = 1;
        idle(3);
        send(mk_all(40), 1);
        send(mk('{-20, 10, 0, 0, 0, 0, 0, 0}), 1);
        idle(3);

        // Randomized configurations and beats.
        for (int p = 0; p < 20; p++) begin
            int rising, thr, hyst, hold;
            rising = $urandom_range(0, 1);
            thr    = $urandom_range(0, 255);
            thr    = thr - 128;
            hyst   = (p % 5 == 0) ? 0 : $urandom_range(0, 40);
            hold   = $urandom_range(0, 4);
            configure(rising, thr, hyst, hold);
            for (int b = 0; b < 40; b++) begin
                send(rand_beat(thr, hyst), ($urandom_range(0, 4) != 0));
            end
            idle(3);
            check_armed("armed_random");
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge divclk);
        chk("drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_edge_trigger.md
Name: adc_edge_trigger

Overview:
- Edge trigger detector between the two's-complement/channel-mux stage and adc_to_datamover, in the divclk domain.
- Consumes 64-bit ADC beats (8 signed 8-bit samples) and passes them through with fixed latency.
- Tags the first beat containing a qualified threshold crossing with a trigger flag and the lane index of the crossing.
- Hysteresis rejects noise; holdoff rate-limits triggers.

Parameters:
- LANES, 8, samples per beat
- SAMPLE_W, 8, bits per signed sample; data width = LANES*SAMPLE_W
- HOLDOFF_W, 16, width of holdoff counter

Ports:
- divclk  in  1  sample clock (125 MHz divclk)
- rst  in  1  synchronous reset, active-high
- in_data  in  64  beat; lane 0 = bits[7:0] = oldest sample, lane 7 = bits[63:56] = newest
- in_valid  in  1  beat qualifier
- cfg_arm  in  1  level; 1 enables triggering, 0 forces IDLE
- cfg_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- cfg_threshold  in  8  signed trigger level
- cfg_hyst  in  8  unsigned hysteresis
- cfg_holdoff  in  16  valid beats to ignore after a trigger
- out_data  out  64  in_data delayed 2 cycles
- out_valid  out  1  in_valid delayed 2 cycles
- out_trig  out  1  1 on the single output beat containing the trigger
- out_trig_idx  out  3  lane of the crossing sample; valid when out_trig=1
- armed  out  1  1 when state is PRIMED

Behaviour:
- Clock and reset: single clock divclk; rst is synchronous, active-high.
- Reset values: out_data=0, out_valid=0, out_trig=0, out_trig_idx=0, armed=0, state=IDLE, holdoff counter=0.
- Latency: exactly 2 cycles for data, valid and trig. Pipeline does not stall; there is no backpressure. in_valid=0 beats propagate as bubbles, and state/counters do not advance on them.
- Stage 1 registers:
  - in_data and in_valid.
  - Per-lane flags hi[i] = (s >= thr) and lo[i] = (s <= thr_lo), evaluated on signed samples.
  - Rising edge: thr_lo = thr - hyst, computed in 10-bit signed and saturated to -128.
  - Falling edge: hi/lo roles swap: hi[i] = (s <= thr); lo[i] = (s >= thr + hyst), saturated to +127.
  - cfg_* are sampled at stage 1 and treated as quasi-static (software changes them only while cfg_arm=0).
- Stage 2: resolves the FSM over lanes 0..7 in order, using a combinational prime chain.
- FSM states:
  - IDLE: cfg_arm=1 -> WAIT_PRIME.
  - WAIT_PRIME: a lane i with lo[i] primes. A trigger at lane j>i in the same beat is allowed. If no trigger, -> PRIMED at beat end.
  - PRIMED: first lane j with hi[j] -> trigger. Set out_trig=1 and out_trig_idx=j, load holdoff=cfg_holdoff, -> HOLDOFF. If cfg_holdoff=0, -> WAIT_PRIME.
  - HOLDOFF: decrement once per valid beat. At 1 -> WAIT_PRIME. Lanes in the beat that expires holdoff are not evaluated.
- Per-beat limits: at most one trigger per beat; lanes after the trigger lane are ignored.
- A sample satisfying both lo and hi (hyst=0, s=thr) primes but does not trigger on that same lane.
- cfg_arm=0 in any state -> IDLE next cycle, holdoff cleared. A trigger already in the pipeline still emerges.
- rst mid-operation: everything returns to reset values next cycle; in-flight beats are discarded.

Optional Feature:
- Macro: TRIG_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running beat counter, incremented per valid input beat, reset to 0 and wrapping at 2^32-1 -> 0.
  - Adds output port out_trig_ts[31:0], holding {counter at trigger beat[28:0], out_trig_idx}. It updates in the same cycle out_trig=1, holds until the next trigger, and resets to 0.
- Undefined: no counter and no port; all other behaviour is identical.

Test Plan:
- Setup: rising, thr=0, hyst=16, holdoff=0, arm=1. Beat lanes {-40,-20,-5,5,20,40,60,80} -> out_trig=1, idx=3, 2 cycles after input; out_data equals input.
- Same config, beat {-10,-5,5,10,...} (never <= -16) -> no trigger. Next beat lane0=-20, lane2=10 -> trigger idx=2.
- Falling, thr=10, hyst=5, holdoff=3. Alternating beats {20 x8} then {0 x8} -> triggers on first falling beat, then suppressed for 3 valid beats, then next qualifying beat triggers.
- Saturation: thr=-120, hyst=50, rising -> thr_lo=-128; lane=-128 primes; lane=-120 triggers.
- in_valid gaps: insert 0-valid bubbles during HOLDOFF=2 -> counter only decrements on valid beats; out_valid mirrors in_valid delayed 2.
- rst asserted while PRIMED, and separately cfg_arm dropped -> armed=0 next cycle; no trigger on a subsequent crossing until re-primed.
